// File: rtl/multi_lane_pipe.sv
// Multi-lane pipeline: each lane is a stage-1 register feeding a show-ahead FIFO.
// Lanes are fully independent; only the clock, reset and flush are shared.
module multi_lane_pipe #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 16,
    localparam int unsigned LVL_W = $clog2(DEPTH + 2)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [NUM_CH-1:0]        i_valid,
    output logic [NUM_CH-1:0]        o_ready,
    input  logic [NUM_CH*DATA_W-1:0] i_data,
    output logic [NUM_CH-1:0]        o_valid,
    input  logic [NUM_CH-1:0]        i_ready,
    output logic [NUM_CH*DATA_W-1:0] o_data,
    input  logic [NUM_CH-1:0]        i_ch_en,
    input  logic                     i_flush,
    output logic [NUM_CH*LVL_W-1:0]  o_level,
    output logic [NUM_CH*CNT_W-1:0]  o_xfer_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    // Extra wrap bit distinguishes full from empty when the indices match.
    localparam int unsigned PW = AW + 1;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        logic              s1_valid_q, s1_valid_d;
        logic [DATA_W-1:0] s1_data_q, s1_data_d;
        logic [PW-1:0]     wptr_q, wptr_d;
        logic [PW-1:0]     rptr_q, rptr_d;
        logic [PW-1:0]     count;
        logic [CNT_W-1:0]  cnt_q, cnt_d;
        logic [DATA_W-1:0] mem_q [DEPTH];
        logic              full, empty, pop, move, ready, accept;

        // Handshake decode for this lane.
        always_comb begin
            count  = wptr_q - rptr_q;
            empty  = (wptr_q == rptr_q);
            full   = (count == PW'(DEPTH));
            pop    = !empty && i_ready[k];
            // Stage 1 may enter a full FIFO when the head leaves on the same edge.
            move   = s1_valid_q && (!full || pop);
            // Gated by reset so upstream never sees ready while the lane is held.
            ready  = i_rst_n && i_ch_en[k] && !i_flush && (!s1_valid_q || move);
            accept = i_valid[k] && ready;
        end

        // Next-state for stage 1, pointers and transfer counter; flush wins over all.
        always_comb begin
            s1_valid_d = s1_valid_q;
            s1_data_d  = s1_data_q;
            wptr_d     = wptr_q;
            rptr_d     = rptr_q;
            cnt_d      = cnt_q;
            if (i_flush) begin
                s1_valid_d = 1'b0;
                wptr_d     = '0;
                rptr_d     = '0;
            end else begin
                if (accept) begin
                    s1_valid_d = 1'b1;
                    s1_data_d  = i_data[k*DATA_W +: DATA_W];
                end else if (move) begin
                    s1_valid_d = 1'b0;
                end
                if (move) begin
                    wptr_d = wptr_q + PW'(1);
                end
                if (pop) begin
                    rptr_d = rptr_q + PW'(1);
                    cnt_d  = cnt_q + CNT_W'(1);
                end
            end
        end

        // Lane control state with asynchronous reset.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                s1_valid_q <= 1'b0;
                s1_data_q  <= '0;
                wptr_q     <= '0;
                rptr_q     <= '0;
                cnt_q      <= '0;
            end else begin
                s1_valid_q <= s1_valid_d;
                s1_data_q  <= s1_data_d;
                wptr_q     <= wptr_d;
                rptr_q     <= rptr_d;
                cnt_q      <= cnt_d;
            end
        end

        // FIFO storage; contents are don't-care after reset so no reset here.
        always_ff @(posedge i_clk) begin
            if (move && !i_flush) begin
                mem_q[wptr_q[AW-1:0]] <= s1_data_q;
            end
        end

        assign o_ready[k]                     = ready;
        assign o_valid[k]                     = !empty;
        assign o_data[k*DATA_W +: DATA_W]     = mem_q[rptr_q[AW-1:0]];
        assign o_level[k*LVL_W +: LVL_W]      = LVL_W'(count) + LVL_W'(s1_valid_q);
        assign o_xfer_cnt[k*CNT_W +: CNT_W]   = cnt_q;
    end

endmodule

// File: tb/tb_multi_lane_pipe.sv
// Self-checking bench for multi_lane_pipe: directed scenarios plus a random phase,
// all compared against a queue-based behavioural model of each lane.
module tb_multi_lane_pipe;

    localparam int NCH = 2;
    localparam int DW  = 8;
    localparam int DEP = 4;
    localparam int CW  = 4;
    localparam int LW  = $clog2(DEP + 2);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NCH-1:0]    valid_i = '0;
    logic [NCH-1:0]    ready_o;
    logic [NCH*DW-1:0] data_i = '0;
    logic [NCH-1:0]    valid_o;
    logic [NCH-1:0]    ready_i = '0;
    logic [NCH*DW-1:0] data_o;
    logic [NCH-1:0]    ch_en = '1;
    logic              flush = 1'b0;
    logic [NCH*LW-1:0] level_o;
    logic [NCH*CW-1:0] cnt_o;

    int ncomp = 0;
    int nfail = 0;

    // Reference model: one optional stage-1 beat plus a FIFO queue per lane.
    bit          m_s1v [NCH];
    logic [DW-1:0] m_s1d [NCH];
    logic [DW-1:0] m_fq  [NCH][$];
    int          m_cnt [NCH];
    logic [DW-1:0] nxt   [NCH];
    int          acc   [NCH];
    bit          rnd_data = 1'b0;

    always #5 clk = ~clk;

    multi_lane_pipe #(
        .NUM_CH(NCH),
        .DATA_W(DW),
        .DEPTH (DEP),
        .CNT_W (CW)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_valid   (valid_i),
        .o_ready   (ready_o),
        .i_data    (data_i),
        .o_valid   (valid_o),
        .i_ready   (ready_i),
        .o_data    (data_o),
        .i_ch_en   (ch_en),
        .i_flush   (flush),
        .o_level   (level_o),
        .o_xfer_cnt(cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_data();
        for (int k = 0; k < NCH; k++) data_i[k*DW +: DW] = nxt[k];
    endtask

    task automatic model_clear();
        for (int k = 0; k < NCH; k++) begin
            m_s1v[k] = 1'b0;
            m_fq[k].delete();
            m_cnt[k] = 0;
        end
    endtask

    // One clock: check outputs mid-cycle, advance the model, step past the edge.
    task automatic cycle();
        @(negedge clk);
        for (int k = 0; k < NCH; k++) begin
            bit pop, mv, rdy;
            int lvl;
            pop = (m_fq[k].size() > 0) && ready_i[k];
            mv  = m_s1v[k] && (m_fq[k].size() < DEP || pop);
            rdy = rst_n && ch_en[k] && !flush && (!m_s1v[k] || mv);
            lvl = m_fq[k].size() + int'(m_s1v[k]);
            chk($sformatf("ready[%0d]", k), 32'(ready_o[k]), 32'(rdy));
            chk($sformatf("valid[%0d]", k), 32'(valid_o[k]), 32'(m_fq[k].size() > 0));
            chk($sformatf("level[%0d]", k), 32'(level_o[k*LW +: LW]), 32'(lvl));
            chk($sformatf("xfer_cnt[%0d]", k), 32'(cnt_o[k*CW +: CW]), 32'(m_cnt[k]));
            if (m_fq[k].size() > 0)
                chk($sformatf("data[%0d]", k), 32'(data_o[k*DW +: DW]), 32'(m_fq[k][0]));
            if (!rst_n) begin
                m_s1v[k] = 1'b0;
                m_fq[k].delete();
                m_cnt[k] = 0;
            end else if (flush) begin
                m_s1v[k] = 1'b0;
                m_fq[k].delete();
            end else begin
                if (pop) begin
                    void'(m_fq[k].pop_front());
                    m_cnt[k] = (m_cnt[k] + 1) % (1 << CW);
                end
                if (mv) m_fq[k].push_back(m_s1d[k]);
                if (valid_i[k] && rdy) begin
                    m_s1v[k] = 1'b1;
                    m_s1d[k] = nxt[k];
                    acc[k]++;
                    nxt[k] = rnd_data ? DW'($urandom) : nxt[k] + 1'b1;
                end else if (mv) begin
                    m_s1v[k] = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
        drive_data();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        valid_i = '0;
        ready_i = '0;
        flush = 1'b0;
        ch_en = '1;
        for (int k = 0; k < NCH; k++) acc[k] = 0;
        model_clear();
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < NCH; k++) begin
            nxt[k] = '0;
            acc[k] = 0;
        end
        model_clear();
        drive_data();
        #1;
        // Reset state checked directly.
        for (int k = 0; k < NCH; k++) begin
            chk("rst_valid", 32'(valid_o[k]), 32'd0);
            chk("rst_level", 32'(level_o[k*LW +: LW]), 32'd0);
            chk("rst_ready", 32'(ready_o[k]), 32'd0);
        end
        do_reset();

        // Latency: lane 0 sends 0xA5, lane 1 idle.
        nxt[0] = 8'hA5;
        drive_data();
        valid_i = 2'b01;
        ready_i = 2'b11;
        cycle();
        valid_i = '0;
        chk("lat_valid_n1", 32'(valid_o[0]), 32'd0);
        cycle();
        chk("lat_valid_n2", 32'(valid_o[0]), 32'd1);
        chk("lat_data_n2", 32'(data_o[DW-1:0]), 32'hA5);
        chk("lat_lane1_idle", 32'(valid_o[1]), 32'd0);
        cycle();

        // Backpressure: stream 0..9 into a stalled lane 0.
        nxt[0] = '0;
        drive_data();
        ready_i = 2'b10;
        valid_i = 2'b01;
        for (int i = 0; i < 10; i++) cycle();
        chk("bp_level", 32'(level_o[LW-1:0]), 32'd5);
        chk("bp_ready", 32'(ready_o[0]), 32'd0);
        chk("bp_head", 32'(data_o[DW-1:0]), 32'd0);

        // Full lane with continuous push and pop keeps level at 5.
        ready_i = 2'b11;
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("full_pp_level", 32'(level_o[LW-1:0]), 32'd5);
        end

        // Drain, build level 3, then flush with valid and ready high.
        valid_i = '0;
        for (int i = 0; i < 8; i++) cycle();
        ready_i = 2'b00;
        valid_i = 2'b01;
        for (int i = 0; i < 3; i++) cycle();
        chk("pre_flush_level", 32'(level_o[LW-1:0]), 32'd3);
        flush = 1'b1;
        ready_i = 2'b11;
        cycle();
        flush = 1'b0;
        valid_i = '0;
        chk("flush_level", 32'(level_o[LW-1:0]), 32'd0);
        chk("flush_valid", 32'(valid_o[0]), 32'd0);
        chk("flush_cnt", 32'(cnt_o[CW-1:0]), 32'(m_cnt[0]));
        cycle();

        // Counter wrap: 17 transfers on lane 1 only.
        do_reset();
        valid_i = 2'b10;
        ready_i = 2'b11;
        for (int i = 0; i < 100 && acc[1] < 17; i++) cycle();
        valid_i = '0;
        for (int i = 0; i < 6; i++) cycle();
        chk("wrap_cnt1", 32'(cnt_o[CW +: CW]), 32'd1);
        chk("wrap_cnt0", 32'(cnt_o[CW-1:0]), 32'd0);

        // Asynchronous reset with four beats in flight on lane 0.
        ready_i = 2'b00;
        valid_i = 2'b01;
        for (int i = 0; i < 4; i++) cycle();
        chk("pre_rst_level", 32'(level_o[LW-1:0]), 32'd4);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < NCH; k++) begin
            chk("arst_valid", 32'(valid_o[k]), 32'd0);
            chk("arst_ready", 32'(ready_o[k]), 32'd0);
            chk("arst_level", 32'(level_o[k*LW +: LW]), 32'd0);
            chk("arst_cnt", 32'(cnt_o[k*CW +: CW]), 32'd0);
        end
        model_clear();
        valid_i = '0;
        cycle();
        rst_n = 1'b1;
        ready_i = 2'b11;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("post_rst_valid", 32'(valid_o[0]), 32'd0);
        end
        valid_i = 2'b01;
        for (int i = 0; i < 4; i++) cycle();

        // Random handshakes, lane enables and occasional flushes.
        rnd_data = 1'b1;
        for (int i = 0; i < 400; i++) begin
            valid_i = NCH'($urandom);
            ready_i = NCH'($urandom);
            ch_en   = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '1;
            flush   = ($urandom_range(0, 19) == 0);
            cycle();
        end
        flush = 1'b0;
        valid_i = '0;
        ready_i = '1;
        for (int i = 0; i < 8; i++) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule

// File: doc/multi_lane_pipe.md
MULTI_LANE_PIPE -- requirements
Module: multi_lane_pipe

Interface
REQ-001 Parameters: NUM_CH, default 2, number of independent lanes (1..16).
REQ-002 Parameters: DATA_W, default 8, per-lane payload width (1..64).
REQ-003 Parameters: DEPTH, default 4, per-lane FIFO entries (power of two, 2..64).
REQ-004 Parameters: CNT_W, default 16, per-lane transfer-counter width.
REQ-005 LVL_W is localparam $clog2(DEPTH+2), the occupancy width.
REQ-006 Port: i_clk  in  1  single clock; all logic on rising edge.
REQ-007 Port: i_rst_n  in  1  reset, asynchronous, active-low.
REQ-008 Port: i_valid  in  NUM_CH  per-lane upstream valid.
REQ-009 Port: o_ready  out  NUM_CH  per-lane upstream ready.
REQ-010 Port: i_data  in  NUM_CH*DATA_W  packed lane payloads; lane k at [k*DATA_W +: DATA_W].
REQ-011 Port: o_valid  out  NUM_CH  per-lane downstream valid.
REQ-012 Port: i_ready  in  NUM_CH  per-lane downstream ready.
REQ-013 Port: o_data  out  NUM_CH*DATA_W  packed output payloads, same packing.
REQ-014 Port: i_ch_en  in  NUM_CH  per-lane accept enable.
REQ-015 Port: i_flush  in  1  synchronous flush of all lanes.
REQ-016 Port: o_level  out  NUM_CH*LVL_W  per-lane occupancy (stage-1 plus FIFO).
REQ-017 Port: o_xfer_cnt  out  NUM_CH*CNT_W  per-lane completed output transfers.

Function
REQ-018 Each lane SHALL be independent: no lane's state or handshake SHALL depend on another lane's signals.
REQ-019 Each lane SHALL be a stage-1 register (s1_valid, s1_data) followed by a show-ahead FIFO of DEPTH entries.
REQ-020 Upstream accept: o_ready[k] = i_ch_en[k] && !i_flush && (!s1_valid || s1 moves this cycle); a beat transfers when i_valid[k] && o_ready[k].
REQ-021 Stage 1 SHALL move into the FIFO when s1_valid && (FIFO not full || FIFO pops this cycle).
REQ-022 Downstream: o_valid[k] = FIFO not empty; o_data[k] = FIFO head; pop when o_valid[k] && i_ready[k].
REQ-023 Latency: a beat accepted at edge N into an empty lane SHALL present o_valid at edge N+2 with data unchanged.
REQ-024 Full throughput: one beat per cycle per lane sustained when i_ready held high.
REQ-025 Full FIFO with simultaneous pop and stage-1 write SHALL both occur; level unchanged, ordering preserved.
REQ-026 o_data SHALL be stable while o_valid[k] && !i_ready[k].
REQ-027 i_ch_en[k]=0 SHALL stop only upstream accept; stage 1 and FIFO continue draining.
REQ-028 i_flush=1 SHALL clear s1_valid and FIFO pointers of all lanes on that edge, overriding any simultaneous push, move or pop; o_xfer_cnt retained.
REQ-029 During i_flush a pop handshake that is visible on the bus SHALL NOT increment o_xfer_cnt.
REQ-030 o_level[k] = FIFO count + s1_valid, updated every edge, range 0..DEPTH+1.
REQ-031 o_xfer_cnt[k] SHALL increment by 1 per pop and wrap from 2^CNT_W-1 to 0.
REQ-032 FIFO pointers SHALL be $clog2(DEPTH)+1 bits with wrap bit for full/empty distinction.

Reset
REQ-033 On i_rst_n low, asynchronously: s1_valid=0, FIFO empty, o_valid=0, o_ready=0, o_level=0, o_xfer_cnt=0; o_data contents don't-care.
REQ-034 Reset asserted mid-transfer SHALL discard all in-flight beats; no beat SHALL reappear after release.
REQ-035 First acceptance possible on the first rising edge after i_rst_n deasserts.

Verification
REQ-036 Latency: NUM_CH=2, lane 0 sends 0xA5 at edge 10, i_ready=1 -> o_valid[0] at edge 12 with 0xA5; lane 1 idle, o_valid[1]=0.
REQ-037 Backpressure: DEPTH=4, i_ready[0]=0, stream 0..9 -> o_ready[0] falls after 5 accepts, o_level[0]=5; release -> 0,1,2,3,4 out in order.
REQ-038 Full pop+push: lane full (level 5), i_ready=1 and i_valid=1 continuous -> one beat/cycle, o_level steady 5, no loss.
REQ-039 Flush: level 3 with i_valid, i_ready high on flush cycle -> next cycle o_level=0, o_valid=0, o_xfer_cnt unchanged.
REQ-040 Counter wrap: CNT_W=4, 17 transfers on lane 1 -> o_xfer_cnt[1]=1; lane 0 count 0.
REQ-041 Reset mid-stream: i_rst_n low for 1 cycle with level 4 -> outputs zero immediately (async), after release o_valid stays 0 until new input.
